// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared FSM state type and counter-width helper for the sequential multiplier.
package seq_mult_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction
endpackage

// File: rtl/seq_mult_param_if.sv
// seq_mult_param_if: request/operand/result bundle between a requester and the multiplier.
interface seq_mult_param_if #(parameter int WIDTH = 16);
  logic                 start94;
  logic                 signed_mode94;
  logic [WIDTH-1:0]     multiplicand94;
  logic [WIDTH-1:0]     multiplier94;
  logic                 ready94;
  logic                 done94;
  logic [2*WIDTH-1:0]   product94;
  modport master (output start94, signed_mode94, multiplicand94, multiplier94,
                  input ready94, done94, product94);
  modport slave (input start94, signed_mode94, multiplicand94, multiplier94,
                 output ready94, done94, product94);
endinterface

// File: rtl/seq_mult_absneg.sv
// seq_mult_absneg: conditional two's-complement negate (magnitude of a signed value when neg = its sign).
module seq_mult_absneg #(parameter int W = 16) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? -a : a;
endmodule

// File: rtl/seq_mult_param.sv
// seq_mult_param: radix-2 shift-add multiplier, signed/unsigned; SEQ_MULT_EARLY_TERM_EN enables early termination.
module seq_mult_param
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic            clk94,
  input  logic            rst94,
  seq_mult_param_if.slave bus
);
  localparam int CW = clog2(WIDTH + 1);
  state_t               state, state_nx;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc, fix_val, fix_res, prod;
  logic [WIDTH-1:0]     mag_a, mag_a_in, mag_b_in;
  logic [WIDTH:0]       sum;
  logic                 neg, neg_in, accept, last, done;
  seq_mult_absneg #(.W(WIDTH)) u_abs_a (
    .a(bus.multiplicand94), .neg(bus.signed_mode94 & bus.multiplicand94[WIDTH-1]), .y(mag_a_in)
  );
  seq_mult_absneg #(.W(WIDTH)) u_abs_b (
    .a(bus.multiplier94), .neg(bus.signed_mode94 & bus.multiplier94[WIDTH-1]), .y(mag_b_in)
  );
  seq_mult_absneg #(.W(2*WIDTH)) u_fix (.a(fix_val), .neg(neg), .y(fix_res));
  // A zero operand never sets neg, so a zero product is never sign-corrected
  assign neg_in = bus.signed_mode94 & (bus.multiplicand94[WIDTH-1] ^ bus.multiplier94[WIDTH-1])
                & (|bus.multiplicand94) & (|bus.multiplier94);
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
`ifdef SEQ_MULT_EARLY_TERM_EN
  // Exit once the unconsumed multiplier bits are zero, after at least one iteration
  assign last = (cnt == '0) || (cnt != CW'(WIDTH) && (acc[WIDTH-1:0] & ~({WIDTH{1'b1}} << cnt)) == '0);
  assign fix_val = acc >> cnt;
`else
  assign last = cnt == '0;
  assign fix_val = acc;
`endif
  assign accept = state == IDLE && bus.start94;
  assign bus.done94 = done;
  assign bus.product94 = prod;
  always_ff @(posedge clk94)
    if (rst94) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (bus.start94 ? RUN : IDLE)
             : state == RUN  ? (last ? FIX : RUN)
             : IDLE;
    bus.ready94 = state == IDLE;
  end
  always_ff @(posedge clk94) begin
    if (rst94) begin
      cnt   <= '0;
      acc   <= '0;
      mag_a <= '0;
      neg   <= 1'b0;
      prod  <= '0;
      done  <= 1'b0;
    end else begin
      if (accept) begin
        mag_a <= mag_a_in;
        acc   <= {{WIDTH{1'b0}}, mag_b_in};
        cnt   <= CW'(WIDTH);
        neg   <= neg_in;
      end else if (state == RUN && !last) begin
        acc <= {sum, acc[WIDTH-1:1]};
        cnt <= cnt - 1'b1;
      end
      if (state == FIX) prod <= fix_res;
      done <= state == FIX;
    end
  end
endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: directed table, corner sequences and random sweep against an arithmetic reference model.
module tb_seq_mult_param;
`ifdef SEQ_MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  typedef struct {
    logic        sm;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
    int          lat_base;
    int          lat_early;
  } vec_t;
  logic clk94 = 1'b0;
  logic rst94 = 1'b1;
  int compared = 0;
  int mismatched = 0;
  always #5 clk94 = ~clk94;
  seq_mult_param_if #(.WIDTH(16)) b16();
  seq_mult_param_if #(.WIDTH(8)) b8();
  seq_mult_param #(.WIDTH(16)) dut16 (.clk94(clk94), .rst94(rst94), .bus(b16.slave));
  seq_mult_param #(.WIDTH(8)) dut8 (.clk94(clk94), .rst94(rst94), .bus(b8.slave));
  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic longint ref_prod(input int w, input logic sm, input longint a, input longint b);
    longint sa = a, sb = b;
    if (sm && a[w-1]) sa = a - (longint'(1) << w);
    if (sm && b[w-1]) sb = b - (longint'(1) << w);
    return (sa * sb) & ((longint'(1) << (2*w)) - 1);
  endfunction
  function automatic int exp_lat(input int w, input logic sm, input longint b);
    longint m = (sm && b[w-1]) ? (longint'(1) << w) - b : b;
    int k = 0;
    if (!EARLY) return w + 2;
    while (m != 0) begin
      m = m >> 1;
      k++;
    end
    return (k == 0 ? 1 : k) + 2;
  endfunction
  task automatic op16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                      output logic [31:0] p, output int lat);
    @(negedge clk94);
    b16.signed_mode94 = sm;
    b16.multiplicand94 = a;
    b16.multiplier94 = b;
    b16.start94 = 1'b1;
    @(posedge clk94);
    #1;
    b16.start94 = 1'b0;
    b16.signed_mode94 = ~sm;
    b16.multiplicand94 = 16'($urandom);
    b16.multiplier94 = 16'($urandom);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk94);
      #1;
      if (b16.done94) begin
        lat = i;
        break;
      end
    end
    p = b16.product94;
  endtask
  task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                     output logic [15:0] p, output int lat);
    @(negedge clk94);
    b8.signed_mode94 = sm;
    b8.multiplicand94 = a;
    b8.multiplier94 = b;
    b8.start94 = 1'b1;
    @(posedge clk94);
    #1;
    b8.start94 = 1'b0;
    b8.signed_mode94 = ~sm;
    b8.multiplicand94 = 8'($urandom);
    b8.multiplier94 = 8'($urandom);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk94);
      #1;
      if (b8.done94) begin
        lat = i;
        break;
      end
    end
    p = b8.product94;
  endtask
  initial begin
    vec_t tbl[11];
    logic [15:0] ba[4];
    logic [15:0] bb[4];
    logic [7:0] cor[5];
    logic [31:0] p;
    logic [15:0] p8;
    int lat;
    int dones;
    tbl[0]  = '{1'b1, 16'hFFFD, 16'h0007, 32'hFFFFFFEB, 18, 5};
    tbl[1]  = '{1'b1, 16'h8000, 16'h8000, 32'h40000000, 18, 18};
    tbl[2]  = '{1'b0, 16'h8000, 16'h8000, 32'h40000000, 18, 18};
    tbl[3]  = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 18, 18};
    tbl[4]  = '{1'b0, 16'h0009, 16'h0005, 32'h0000002D, 18, 5};
    tbl[5]  = '{1'b0, 16'h1234, 16'h0000, 32'h00000000, 18, 3};
    tbl[6]  = '{1'b1, 16'h0000, 16'hFFFF, 32'h00000000, 18, 3};
    tbl[7]  = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, 18, 3};
    tbl[8]  = '{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000, 18, 18};
    tbl[9]  = '{1'b0, 16'h0001, 16'hFFFF, 32'h0000FFFF, 18, 18};
    tbl[10] = '{1'b1, 16'hFFFF, 16'h7FFF, 32'hFFFF8001, 18, 17};
    cor = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    b16.start94 = 1'b0;
    b16.signed_mode94 = 1'b0;
    b16.multiplicand94 = '0;
    b16.multiplier94 = '0;
    b8.start94 = 1'b0;
    b8.signed_mode94 = 1'b0;
    b8.multiplicand94 = '0;
    b8.multiplier94 = '0;
    repeat (3) @(posedge clk94);
    #1;
    chk("rst_ready16", b16.ready94, 1);
    chk("rst_done16", b16.done94, 0);
    chk("rst_prod16", b16.product94, 0);
    chk("rst_ready8", b8.ready94, 1);
    chk("rst_prod8", b8.product94, 0);
    rst94 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      op16(tbl[i].sm, tbl[i].a, tbl[i].b, p, lat);
      chk($sformatf("tbl%0d_prod", i), p, tbl[i].exp);
      chk($sformatf("tbl%0d_lat", i), lat, EARLY ? tbl[i].lat_early : tbl[i].lat_base);
      chk($sformatf("tbl%0d_ready", i), b16.ready94, 1);
    end
    ba = '{16'h0003, 16'hFFF0, 16'h0100, 16'h7FFF};
    bb = '{16'h0005, 16'h0011, 16'h0000, 16'hFFFE};
    @(negedge clk94);
    b16.signed_mode94 = 1'b1;
    b16.multiplicand94 = ba[0];
    b16.multiplier94 = bb[0];
    b16.start94 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lat = -1;
      for (int j = 1; j <= 60; j++) begin
        @(posedge clk94);
        #1;
        if (b16.done94) begin
          lat = j;
          break;
        end
      end
      chk($sformatf("b2b%0d_prod", i), b16.product94, ref_prod(16, 1'b1, ba[i], bb[i]));
      chk($sformatf("b2b%0d_gap", i), lat, exp_lat(16, 1'b1, bb[i]) + 1);
      if (i < 3) begin
        b16.multiplicand94 = ba[i+1];
        b16.multiplier94 = bb[i+1];
      end else b16.start94 = 1'b0;
    end
    @(negedge clk94);
    b16.signed_mode94 = 1'b0;
    b16.multiplicand94 = 16'h1234;
    b16.multiplier94 = 16'h5678;
    b16.start94 = 1'b1;
    @(posedge clk94);
    #1;
    b16.start94 = 1'b0;
    repeat (5) @(posedge clk94);
    #1;
    rst94 = 1'b1;
    b16.start94 = 1'b1;
    @(posedge clk94);
    #1;
    rst94 = 1'b0;
    b16.start94 = 1'b0;
    chk("midrst_done", b16.done94, 0);
    chk("midrst_prod", b16.product94, 0);
    chk("midrst_ready", b16.ready94, 1);
    dones = 0;
    repeat (25) begin
      @(posedge clk94);
      #1;
      if (b16.done94) dones++;
    end
    chk("midrst_no_done", dones, 0);
    op16(1'b0, 16'd2, 16'd3, p, lat);
    chk("after_rst_prod", p, 6);
    chk("after_rst_lat", lat, exp_lat(16, 1'b0, 3));
    for (int sm = 0; sm < 2; sm++) begin
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) begin
          op8(1'(sm), cor[i], cor[j], p8, lat);
          chk($sformatf("cor_m%0d_%0h_%0h", sm, cor[i], cor[j]), p8, ref_prod(8, 1'(sm), cor[i], cor[j]));
          chk($sformatf("cor_lat_m%0d_%0h", sm, cor[j]), lat, exp_lat(8, 1'(sm), cor[j]));
        end
      for (int n = 0; n < 300; n++) begin
        logic [7:0] ra, rb;
        ra = 8'($urandom);
        rb = 8'($urandom);
        op8(1'(sm), ra, rb, p8, lat);
        chk($sformatf("rnd_m%0d_%0h_%0h", sm, ra, rb), p8, ref_prod(8, 1'(sm), ra, rb));
        chk($sformatf("rnd_lat_m%0d_%0h", sm, rb), lat, exp_lat(8, 1'(sm), rb));
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
